eeprom_bist_seq: RTL and testbench
==================================

EEPROM_BIST_SEQ -- requirements
Module: eeprom_bist_seq

Sits upstream of the I2C EEPROM read/write controller. Issues a block of byte writes through that controller, then reads the block back and checks it.

Interface
REQ-001 Parameter GAP_CYC, default 16: idle cycles inserted after every completed transaction; legal range 1..65535.
REQ-002 Parameter TIMEOUT_CYC, default 4095: maximum cycles to wait for ACK on one transaction; legal range 1..65535.
REQ-003 CLK  input  1  single clock; all sequential logic on posedge CLK.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  run request, sampled in IDLE only.
REQ-006 BASE_ADDR  input  11  first EEPROM byte address, captured at START.
REQ-007 LEN  input  8  byte count, captured at START; 0 means no transactions.
REQ-008 SEED  input  8  pattern seed, captured at START.
REQ-009 WR  output  1  write request to the controller.
REQ-010 RD  output  1  read request to the controller.
REQ-011 ADDR  output  11  byte address to the controller.
REQ-012 DATA  inout  8  parallel data bus; driven by this block only while WR=1, high-Z otherwise.
REQ-013 ACK  input  1  controller completion pulse, one or more cycles high.
REQ-014 BUSY  output  1  high from the cycle after START is accepted until FIN.
REQ-015 DONE  output  1  one-cycle pulse at end of run.
REQ-016 ERR_CNT  output  8  readback mismatch count; saturates at 255.
REQ-017 TIMEOUT  output  1  set when an ACK wait expires.
REQ-018 FAIL  output  1  combinational: (ERR_CNT!=0) | TIMEOUT.

Function
REQ-019 States: IDLE, W_REQ, W_GAP, R_REQ, R_GAP, FIN; one-hot encoding.
REQ-020 Byte index k runs 0..LEN-1.
  - Address(k) = BASE_ADDR + k mod 2048; 0x7FF wraps to 0x000.
  - Pattern(k) = SEED + k mod 256.
REQ-021 IDLE with START=1: capture inputs, clear ERR_CNT and TIMEOUT, set k=0.
  - LEN!=0: next state W_REQ.
  - LEN=0: next state FIN.
REQ-022 START while not in IDLE is ignored.
REQ-023 W_REQ: WR=1, ADDR=Address(k), DATA=Pattern(k); all three held stable until ACK is sampled high.
REQ-024 On the ACK-high cycle in W_REQ, next state W_GAP; WR=0 and DATA=Z from the next cycle.
REQ-025 W_GAP lasts exactly GAP_CYC cycles, then:
  - k<LEN-1: k+1, next state W_REQ.
  - otherwise: k=0, next state R_REQ.
REQ-026 R_REQ: RD=1, ADDR=Address(k), DATA=Z; held until ACK is sampled high.
REQ-027 On the ACK-high cycle in R_REQ:
  - sample DATA and compare with Pattern(k);
  - on mismatch, ERR_CNT increments unless it is already 255;
  - next state R_GAP; RD=0 from the next cycle.
REQ-028 R_GAP lasts GAP_CYC cycles, then:
  - k<LEN-1: k+1, next state R_REQ.
  - otherwise: next state FIN.
REQ-029 WR and RD are never high in the same cycle.
REQ-030 Each new request rises at least GAP_CYC cycles after the previous ACK.
REQ-031 ACK outside W_REQ/R_REQ is ignored.
REQ-032 ACK held high for several cycles completes only one transaction.
REQ-033 Timeout counter clears on entry to W_REQ or R_REQ. If it reaches TIMEOUT_CYC without ACK:
  - WR=0, RD=0, DATA=Z;
  - TIMEOUT=1;
  - next state FIN; remaining bytes are skipped.
REQ-034 FIN: DONE=1 and BUSY=0 for one cycle, next state IDLE.
REQ-035 ERR_CNT and TIMEOUT hold their values after FIN until the next accepted START.

Reset
REQ-036 RESET=0 immediately forces, independent of CLK:
  - state IDLE;
  - WR=0, RD=0, ADDR=0, DATA=Z;
  - BUSY=0, DONE=0, ERR_CNT=0, TIMEOUT=0;
  - k=0, gap and timeout counters 0.
REQ-037 Reset asserted mid-transaction aborts it with no DONE pulse.
REQ-038 The first START is accepted on the first posedge after RESET rises.

Verification
REQ-039 LEN=3, BASE_ADDR=0x7FE, SEED=0xA0, responder ACKs after 20 cycles and returns the written data.
  - Writes: 0x7FE/A0, 0x7FF/A1, 0x000/A2.
  - Then three reads at the same addresses.
  - Result: ERR_CNT=0, FAIL=0, exactly one DONE.
REQ-040 As REQ-039, but the responder returns 0x00 on the second read -> ERR_CNT=1, FAIL=1, DONE once.
REQ-041 Responder never ACKs, TIMEOUT_CYC=50 -> WR falls 50 cycles after rising, TIMEOUT=1, DONE pulses, RD never asserts.
REQ-042 LEN=0 -> DONE within 2 cycles of START; WR and RD stay 0.
REQ-043 START pulsed again while BUSY=1 -> ignored; the run completes with the original LEN, BASE_ADDR and SEED.
REQ-044 RESET driven low between clock edges during W_REQ -> WR=0, DATA=Z, BUSY=0 at once; no DONE pulse.

Source files
------------

// File: rtl/eeprom_bist_seq.sv
// Built-in self test sequencer for an I2C EEPROM controller: writes a seeded
// byte pattern over an address block, then reads it back and counts mismatches.
module eeprom_bist_seq #(
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [10:0] BASE_ADDR,
  input  logic [7:0]  LEN,
  input  logic [7:0]  SEED,
  output logic        WR,
  output logic        RD,
  output logic [10:0] ADDR,
  inout  wire  [7:0]  DATA,
  input  logic        ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  ERR_CNT,
  output logic        TIMEOUT,
  output logic        FAIL
);

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_W_REQ = 6'b000010;
  localparam logic [5:0] S_W_GAP = 6'b000100;
  localparam logic [5:0] S_R_REQ = 6'b001000;
  localparam logic [5:0] S_R_GAP = 6'b010000;
  localparam logic [5:0] S_FIN   = 6'b100000;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

  logic [5:0]  state_reg, state_next;
  logic [7:0]  k_reg, k_next;
  logic [10:0] base_reg, base_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  seed_reg, seed_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic        timeout_reg, timeout_next;
  logic        ack_armed_reg, ack_armed_next;

  logic [7:0]  pattern;
  logic [10:0] addr_cur;
  logic [8:0]  k_inc;
  logic        more_bytes;
  logic        ack_hit;

  assign pattern    = seed_reg + k_reg;
  assign addr_cur   = base_reg + {3'b000, k_reg};
  assign k_inc      = {1'b0, k_reg} + 9'd1;
  assign more_bytes = k_inc < {1'b0, len_reg};
  // An ACK completes a request only if ACK was seen low since the last
  // completion, so one long ACK pulse never finishes two transactions.
  assign ack_hit    = ACK & ack_armed_reg;

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    base_next      = base_reg;
    len_next       = len_reg;
    seed_next      = seed_reg;
    gap_cnt_next   = gap_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    timeout_next   = timeout_reg;
    ack_armed_next = ACK ? ack_armed_reg : 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (START) begin
          base_next    = BASE_ADDR;
          len_next     = LEN;
          seed_next    = SEED;
          err_cnt_next = 8'd0;
          timeout_next = 1'b0;
          k_next       = 8'd0;
          to_cnt_next  = 16'd0;
          state_next   = (LEN != 8'd0) ? S_W_REQ : S_FIN;
        end
      end
      S_W_REQ, S_R_REQ: begin
        if (ack_hit) begin
          ack_armed_next = 1'b0;
          gap_cnt_next   = 16'd0;
          if (state_reg == S_W_REQ) begin
            state_next = S_W_GAP;
          end else begin
            state_next = S_R_GAP;
            if (DATA != pattern && err_cnt_reg != 8'hFF) begin
              err_cnt_next = err_cnt_reg + 8'd1;
            end
          end
        end else if (to_cnt_reg == TO_LAST) begin
          timeout_next = 1'b1;
          state_next   = S_FIN;
        end else begin
          to_cnt_next = to_cnt_reg + 16'd1;
        end
      end
      S_W_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          to_cnt_next = 16'd0;
          if (more_bytes) begin
            k_next     = k_inc[7:0];
            state_next = S_W_REQ;
          end else begin
            k_next     = 8'd0;
            state_next = S_R_REQ;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      S_R_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          if (more_bytes) begin
            k_next      = k_inc[7:0];
            to_cnt_next = 16'd0;
            state_next  = S_R_REQ;
          end else begin
            state_next = S_FIN;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= S_IDLE;
      k_reg         <= 8'd0;
      base_reg      <= 11'd0;
      len_reg       <= 8'd0;
      seed_reg      <= 8'd0;
      gap_cnt_reg   <= 16'd0;
      to_cnt_reg    <= 16'd0;
      err_cnt_reg   <= 8'd0;
      timeout_reg   <= 1'b0;
      ack_armed_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      base_reg      <= base_next;
      len_reg       <= len_next;
      seed_reg      <= seed_next;
      gap_cnt_reg   <= gap_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      timeout_reg   <= timeout_next;
      ack_armed_reg <= ack_armed_next;
    end
  end

  // Request strobes decode straight from the state so reset clears them at once.
  assign WR      = (state_reg == S_W_REQ);
  assign RD      = (state_reg == S_R_REQ);
  assign ADDR    = (WR | RD) ? addr_cur : 11'd0;
  assign DATA    = WR ? pattern : 8'bzzzz_zzzz;
  assign BUSY    = (state_reg != S_IDLE) && (state_reg != S_FIN);
  assign DONE    = (state_reg == S_FIN);
  assign ERR_CNT = err_cnt_reg;
  assign TIMEOUT = timeout_reg;
  assign FAIL    = (err_cnt_reg != 8'd0) | timeout_reg;

endmodule

// File: tb/tb_eeprom_bist_seq.sv
// Scoreboard bench for eeprom_bist_seq: expected requests and run results are
// queued at START; a monitor pops them as the DUT issues requests and DONE.
module tb_eeprom_bist_seq;
  localparam int GAP = 5;
  localparam int TMO = 50;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        ACK = 1'b0;
  logic [10:0] BASE_ADDR = '0;
  logic [7:0]  LEN = '0;
  logic [7:0]  SEED = '0;
  logic        WR, RD, BUSY, DONE, TIMEOUT, FAIL;
  logic [10:0] ADDR;
  logic [7:0]  ERR_CNT;
  wire  [7:0]  DATA;
  logic        tb_den = 1'b0;
  logic [7:0]  tb_dout = '0;

  assign DATA = tb_den ? tb_dout : 8'bzzzz_zzzz;

  eeprom_bist_seq #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
    .SEED(SEED), .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA), .ACK(ACK),
    .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT), .TIMEOUT(TIMEOUT), .FAIL(FAIL)
  );

  always #5 CLK = ~CLK;

  typedef struct {int kind; int addr; int data; int err; int tmo;} exp_t; // kind 0=wr 1=rd 2=done
  exp_t sb_q[$];

  int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int exp_err = 0, exp_tmo = 0;
  bit no_ack = 0;
  int lat_cfg = 20;
  logic [255:0] cmask_cfg = '0;
  int rd_idx = 0;
  logic [7:0] mem [0:2047];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: models the EEPROM controller with a byte array behind it.
  initial begin
    bit is_rd, ok;
    int a, lat;
    logic [7:0] d;
    foreach (mem[i]) mem[i] = 8'h00;
    forever begin
      @(negedge CLK);
      if (RESET && (WR || RD) && !ACK && !no_ack) begin
        is_rd = RD; a = int'(ADDR); d = DATA; ok = 1;
        lat = (lat_cfg < 0) ? int'($urandom_range(0, 20)) : lat_cfg;
        for (int i = 0; i < lat && ok; i++) begin
          @(negedge CLK);
          if (!RESET || !(WR || RD)) ok = 0;
        end
        if (ok) begin
          if (is_rd) begin
            tb_dout = cmask_cfg[rd_idx] ? (mem[a] ^ 8'hFF) : mem[a];
            rd_idx++;
            tb_den = 1'b1;
          end else begin
            mem[a] = d;
          end
          ACK = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge CLK);
          ACK = 1'b0;
          tb_den = 1'b0;
        end
      end
    end
  end

  // Monitor: compares each new request and each DONE against the queue head.
  initial begin
    logic pw, pr;
    int last_ack, wr_rise, wr_len;
    bit first;
    exp_t e;
    pw = 0; pr = 0; last_ack = 0; wr_rise = 0; wr_len = 0; first = 1;
    forever begin
      @(negedge CLK);
      #1;
      cyc++;
      if (!RESET) begin
        first = 1; pw = 0; pr = 0;
        continue;
      end
      if (WR && RD) chk("wr_rd_exclusive", 32'd1, 32'd0);
      if (WR && !pw) wr_rise = cyc;
      if (!WR && pw) wr_len = cyc - wr_rise;
      if ((WR && !pw) || (RD && !pr)) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_req", {31'd0, RD}, 32'd9);
        end else begin
          e = sb_q.pop_front();
          chk("req_kind", RD ? 32'd1 : 32'd0, e.kind);
          chk("req_addr", {21'd0, ADDR}, e.addr);
          if (WR) chk("wr_data", {24'd0, DATA}, e.data);
          if (!first) chk("req_gap", cyc - last_ack, GAP + 1);
          first = 0;
        end
      end
      if (ACK && (WR || RD)) last_ack = cyc;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
        first = 1;
        chk("done_busy", {31'd0, BUSY}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_kind", 32'd2, e.kind);
          chk("err_cnt", {24'd0, ERR_CNT}, e.err);
          chk("timeout", {31'd0, TIMEOUT}, e.tmo);
          chk("fail", {31'd0, FAIL}, ((e.err != 0) || (e.tmo != 0)) ? 32'd1 : 32'd0);
          if (e.tmo != 0) chk("wr_timeout_len", wr_len, TMO);
        end
      end
      pw = WR; pr = RD;
    end
  end

  // mode: 0 normal responder, 2 responder never ACKs
  task automatic issue(input int len, input int base, input int seed, input int mode,
                       input int lat, input logic [255:0] cmask);
    int nerr;
    nerr = 0;
    for (int k = 0; k < len; k++) begin
      sb_q.push_back('{0, (base + k) % 2048, (seed + k) % 256, 0, 0});
      if (mode == 2) break;
    end
    if (mode != 2) begin
      for (int k = 0; k < len; k++) begin
        sb_q.push_back('{1, (base + k) % 2048, 0, 0, 0});
        if (cmask[k]) nerr++;
      end
    end
    exp_err = (nerr > 255) ? 255 : nerr;
    exp_tmo = (mode == 2 && len != 0) ? 1 : 0;
    sb_q.push_back('{2, 0, 0, exp_err, exp_tmo});
    no_ack = (mode == 2);
    lat_cfg = lat;
    cmask_cfg = cmask;
    rd_idx = 0;
    START = 1'b1; LEN = 8'(len); BASE_ADDR = 11'(base); SEED = 8'(seed);
    start_cyc = cyc + 1;
    @(negedge CLK);
    START = 1'b0; LEN = 8'($urandom); BASE_ADDR = 11'($urandom); SEED = 8'($urandom);
  endtask

  task automatic finish_run(input string name);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 20000) begin
      @(negedge CLK);
      i++;
    end
    if (sb_q.size() != 0) begin
      chk({name, "_complete"}, sb_q.size(), 0);
      sb_q.delete();
    end
    repeat (3) @(negedge CLK);
    #2;
    chk({name, "_err_hold"}, {24'd0, ERR_CNT}, exp_err);
    chk({name, "_tmo_hold"}, {31'd0, TIMEOUT}, exp_tmo);
    chk({name, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    logic [255:0] m;
    int dn, i;
    repeat (3) @(negedge CLK);
    #2;
    chk("rst_wr", {31'd0, WR}, 0);
    chk("rst_rd", {31'd0, RD}, 0);
    chk("rst_addr", {21'd0, ADDR}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_done", {31'd0, DONE}, 0);
    chk("rst_err", {24'd0, ERR_CNT}, 0);
    chk("rst_tmo", {31'd0, TIMEOUT}, 0);
    chk("rst_fail", {31'd0, FAIL}, 0);

    // Wrap-around block, START on the first edge after reset release.
    @(negedge CLK);
    RESET = 1'b1;
    issue(3, 'h7FE, 'hA0, 0, 20, '0);
    #2 chk("busy_after_start", {31'd0, BUSY}, 1);
    finish_run("wrap_clean");

    m = '0; m[1] = 1'b1;
    issue(3, 'h7FE, 'hA0, 0, 20, m);
    finish_run("wrap_bad_read");

    issue(0, 'h123, 'h55, 0, 20, '0);
    finish_run("len_zero");
    chk("len_zero_latency", done_cyc - start_cyc, 1);

    // Second START while busy must not disturb the run.
    issue(4, 'h3F0, 'h10, 0, -1, '0);
    repeat (30) @(negedge CLK);
    START = 1'b1; LEN = 8'd200; BASE_ADDR = 11'h111; SEED = 8'h77;
    @(negedge CLK);
    START = 1'b0;
    finish_run("restart_ignored");

    for (int r = 0; r < 8; r++) begin
      m = '0;
      for (int k = 0; k < 256; k++) m[k] = ($urandom_range(0, 3) == 0);
      issue($urandom_range(1, 8), $urandom_range(0, 2047), $urandom_range(0, 255), 0, -1, m);
      finish_run($sformatf("rand%0d", r));
    end

    issue(3, $urandom_range(0, 2047), $urandom_range(0, 255), 2, 0, '0);
    finish_run("no_ack");

    // Asynchronous reset in the middle of a write request.
    issue(4, $urandom_range(0, 2047), $urandom_range(0, 255), 0, 20, '0);
    i = 0;
    while (!WR && i < 100) begin
      @(negedge CLK);
      #1;
      i++;
    end
    chk("mid_wr_seen", {31'd0, WR}, 1);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_wr", {31'd0, WR}, 0);
    chk("async_rst_busy", {31'd0, BUSY}, 0);
    chk("async_rst_addr", {21'd0, ADDR}, 0);
    sb_q.delete();
    dn = done_cnt;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (40) @(negedge CLK);
    chk("abort_no_done", done_cnt, dn);

    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    issue(5, $urandom_range(0, 2047), $urandom_range(0, 255), 0, -1, '0);
    finish_run("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
